audio_i2s_tx: RTL and testbench

Stereo I2S transmitter driven directly by the 12.288 MHz audio master clock from the audio PLL. It accepts stereo PCM samples through a valid/ready handshake into a 2-entry buffer. It generates BCLK, LRCK and serial data for the audio DAC at 48 kHz, 64 BCLK per frame. Sits between the core's audio mixer (through the existing clock-domain crossing) and the DAC pins.

---
 rtl/audio_i2s_pkg.sv | 27 ++
 rtl/audio_sample_fifo2.sv | 55 +++++
 rtl/audio_i2s_tx.sv | 150 +++++++++++++++
 tb/tb_audio_i2s_tx.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_i2s_pkg.sv
// Shared definitions for the I2S transmitter: frame geometry, counter widths
// and the stereo sample pair carried through the input buffer.
package audio_i2s_pkg;

  localparam int SLOT_BITS    = 32;
  localparam int FRAME_BITS   = 64;
  localparam int BIT_CNT_W    = $clog2(FRAME_BITS);
  localparam int POS_W        = $clog2(SLOT_BITS);
  localparam int SAMPLE_MAX_W = 24;

  // Samples are stored MSB-justified in the widest legal field, so the
  // serialiser always shifts out of the same bit position whatever SAMPLE_W
  // the user picks; the unused low bits are constant zero.
  typedef struct packed {
    logic [SAMPLE_MAX_W-1:0] left;
    logic [SAMPLE_MAX_W-1:0] right;
  } sample_pair_t;

  // Move a zero-extended sample of the given width up to the field MSB.
  function automatic logic [SAMPLE_MAX_W-1:0] msb_justify(
    input logic [SAMPLE_MAX_W-1:0] sample,
    input int unsigned             width
  );
    return sample << (SAMPLE_MAX_W - width);
  endfunction

endpackage

// File: rtl/audio_sample_fifo2.sv
// Two-entry synchronous FIFO holding stereo sample pairs between the producer
// handshake and the frame-rate pop of the serialiser.
module audio_sample_fifo2
  import audio_i2s_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_push,
  input  sample_pair_t i_data,
  input  logic         i_pop,
  output sample_pair_t o_data,
  output logic         o_full,
  output logic         o_empty
);

  sample_pair_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Write the pushed pair into the slot under the write pointer.
  // NOTE: storage is not reset; occupancy lives in r_count, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Advance pointers and track occupancy.
  // NOTE: non-blocking assignments make every register here sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: 64 BCLK per frame, MCLK_DIV clk cycles per BCLK,
// left/right samples MSB first with the standard one-bit delay after LRCK.
// Optional build macro AUDIO_I2S_TX_UNDERRUN_HOLD_EN: on underrun, replay the
// last popped pair instead of sending silence.
module audio_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int MCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  output logic                i2s_bclk,
  output logic                i2s_lrck,
  output logic                i2s_dat,
  output logic                underrun
);

  localparam int               DIV_W    = $clog2(MCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(SAMPLE_W);
  localparam int               SH_MSB   = SAMPLE_MAX_W - 1;

  logic [DIV_W-1:0]     r_div_cnt;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [SAMPLE_MAX_W-1:0] r_sh_l;
  logic [SAMPLE_MAX_W-1:0] r_sh_r;
  logic                 r_bclk;
  logic                 r_lrck;
  logic                 r_dat;
  logic                 r_underrun;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_load;
  logic                 w_pop;
  logic [POS_W-1:0]     w_pos;
  sample_pair_t         w_push_pair;
  sample_pair_t         w_fifo_data;
  sample_pair_t         w_fill;
  sample_pair_t         w_load_pair;

  assign s_ready  = !w_full;
  assign w_push   = s_valid && !w_full;
  assign w_load   = enable && (r_div_cnt == '0) && (r_bit_cnt == '0);
  assign w_pop    = w_load && !w_empty;
  assign w_pos    = r_bit_cnt[POS_W-1:0];

  assign w_push_pair.left  = msb_justify(SAMPLE_MAX_W'(s_left), SAMPLE_W);
  assign w_push_pair.right = msb_justify(SAMPLE_MAX_W'(s_right), SAMPLE_W);

  audio_sample_fifo2 u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_push_pair),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
  sample_pair_t r_last;

  // Remember the most recent pair actually popped, for replay on underrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= '0;
    end else if (w_pop) begin
      r_last <= w_fifo_data;
    end
  end

  assign w_fill = r_last;
`else
  assign w_fill = '0;
`endif

  assign w_load_pair = w_pop ? w_fifo_data : w_fill;

  // Clock divider and bit position within the frame; disable parks both at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Registered pin drivers and shift registers; data changes only on BCLK fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_underrun <= 1'b0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
    end else if (!enable) begin
      r_bclk     <= 1'b0;
      r_lrck     <= 1'b0;
      r_dat      <= 1'b0;
      r_underrun <= 1'b0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
    end else begin
      r_bclk     <= (r_div_cnt >= DIV_HALF);
      r_lrck     <= r_bit_cnt[BIT_CNT_W-1];
      r_underrun <= w_load && w_empty;
      if (w_load) begin
        r_sh_l <= w_load_pair.left;
        r_sh_r <= w_load_pair.right;
        r_dat  <= 1'b0;
      end else if (r_div_cnt == '0) begin
        if ((w_pos != '0) && (w_pos <= LAST_POS)) begin
          if (r_bit_cnt[BIT_CNT_W-1]) begin
            r_dat  <= r_sh_r[SH_MSB];
            r_sh_r <= r_sh_r << 1;
          end else begin
            r_dat  <= r_sh_l[SH_MSB];
            r_sh_l <= r_sh_l << 1;
          end
        end else begin
          r_dat <= 1'b0;
        end
      end
    end
  end

  assign i2s_bclk = r_bclk;
  assign i2s_lrck = r_lrck;
  assign i2s_dat  = r_dat;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx. Expected frames come from a
// frame-level model: each load edge pops the oldest pair transferred strictly
// before it, and a slot carries p=1..SAMPLE_W as sample bits MSB first.
module tb_audio_i2s_tx;

  localparam int SW        = 16;
  localparam int DIV       = 4;
  localparam int FRAME_CYC = 64 * DIV;
  localparam logic [63:0] LR_EXP = {32'hFFFF_FFFF, 32'h0000_0000};

  typedef struct {
    logic [SW-1:0] l;
    logic [SW-1:0] r;
    int            edge_n;
  } tb_pair_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [SW-1:0] s_left = '0;
  logic [SW-1:0] s_right = '0;
  logic          i2s_bclk;
  logic          i2s_lrck;
  logic          i2s_dat;
  logic          underrun;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            prev_bclk = 1'b0;
  logic [63:0]   cap_dat;
  logic [63:0]   cap_lr;
  int            cap_n = 0;
  int            ur_cnt = 0;
  int            load_edge = 0;
  int            prod_mode = 0;
  int            sched_edge = -1;
  logic [SW-1:0] sched_l = '0;
  logic [SW-1:0] sched_r = '0;
  tb_pair_t      q[$];
  int            xfer_edges[$];
  tb_pair_t      last;

  audio_i2s_tx #(.SAMPLE_W(SW), .MCLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_left   (s_left),
    .s_right  (s_right),
    .i2s_bclk (i2s_bclk),
    .i2s_lrck (i2s_lrck),
    .i2s_dat  (i2s_dat),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // One clock: record handshake transfers, sample pins on BCLK rise, drive next inputs.
  task automatic step();
    bit xfer;
    tb_pair_t p;
    @(negedge clk);
    xfer = s_valid && s_ready;
    @(posedge clk);
    cyc++;
    if (xfer) begin
      p.l = s_left; p.r = s_right; p.edge_n = cyc;
      q.push_back(p);
      xfer_edges.push_back(cyc);
    end
    #1;
    if (i2s_bclk && !prev_bclk && cap_n < 64) begin
      cap_dat[cap_n] = i2s_dat;
      cap_lr[cap_n]  = i2s_lrck;
      cap_n++;
    end
    prev_bclk = i2s_bclk;
    if (underrun) ur_cnt++;
    if (prod_mode == 1) begin
      s_valid = 1'b1;
      if (xfer) begin s_left = SW'($urandom); s_right = SW'($urandom); end
    end else if (prod_mode == 2) begin
      if (xfer || !s_valid) begin s_left = SW'($urandom); s_right = SW'($urandom); end
      s_valid = ($urandom_range(0, 3) != 0);
    end else if (cyc + 1 == sched_edge) begin
      s_valid = 1'b1; s_left = sched_l; s_right = sched_r;
    end else if (xfer) begin
      s_valid = 1'b0;
    end
  endtask

  function automatic void model_load(input int ld, output tb_pair_t e, output bit eu);
    if (q.size() > 0 && q[0].edge_n < ld) begin
      e = q.pop_front();
      last = e;
      eu = 1'b0;
    end else begin
      eu = 1'b1;
`ifdef AUDIO_I2S_TX_UNDERRUN_HOLD_EN
      e = last;
`else
      e.l = '0; e.r = '0; e.edge_n = 0;
`endif
    end
  endfunction

  function automatic logic [63:0] exp_dat(input logic [SW-1:0] l, input logic [SW-1:0] r);
    logic [63:0]   d;
    logic [SW-1:0] w;
    int            p;
    d = '0;
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      w = (b < 32) ? l : r;
      if (p >= 1 && p <= SW) d[b] = w[SW-p];
    end
    return d;
  endfunction

  task automatic do_enable();
    enable = 1'b1;
    load_edge = cyc + 1;
  endtask

  task automatic do_disable();
    enable = 1'b0;
    step();
    step();
  endtask

  // Capture one full frame (64 BCLK rises) and compare against the model.
  task automatic run_frame(input string name);
    tb_pair_t    e;
    bit          eu;
    int          budget;
    logic [63:0] ed;
    cap_n = 0; cap_dat = '0; cap_lr = '0; ur_cnt = 0; budget = 0;
    while (cap_n < 64 && budget < FRAME_CYC + 16) begin
      step();
      budget++;
    end
    model_load(load_edge, e, eu);
    ed = exp_dat(e.l, e.r);
    checks++;
    if (cap_n != 64) begin failures++; $display("FAIL %s bclk_count: got %0d expected 64", name, cap_n); end
    checks++;
    if (cap_dat !== ed) begin failures++; $display("FAIL %s dat: got %h expected %h", name, cap_dat, ed); end
    checks++;
    if (cap_lr !== LR_EXP) begin failures++; $display("FAIL %s lrck: got %h expected %h", name, cap_lr, LR_EXP); end
    checks++;
    if (ur_cnt != int'(eu)) begin failures++; $display("FAIL %s underrun_pulses: got %0d expected %0d", name, ur_cnt, eu); end
    load_edge += FRAME_CYC;
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset s_ready: got %b expected 1", s_ready); end
    checks++; if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL reset bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrck !== 1'b0) begin failures++; $display("FAIL reset lrck: got %b expected 0", i2s_lrck); end
    checks++; if (i2s_dat !== 1'b0) begin failures++; $display("FAIL reset dat: got %b expected 0", i2s_dat); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset underrun: got %b expected 0", underrun); end
    reset_n = 1'b1;
    step(); step();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL idle s_ready: got %b expected 1", s_ready); end
    checks++; if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL idle bclk: got %b expected 0", i2s_bclk); end
  endtask

  task automatic test_basic();
    s_valid = 1'b1; s_left = 16'hA55A; s_right = 16'h0F0F;
    step();
    do_enable();
    run_frame("basic");
    do_disable();
  endtask

  task automatic test_underrun();
    s_valid = 1'b1; s_left = 16'h1234; s_right = 16'h5678;
    step();
    do_enable();
    repeat (3) run_frame("underrun");
    do_disable();
  endtask

  task automatic test_backpressure();
    int base;
    int first;
    int n;
    prod_mode = 1; s_valid = 1'b1; s_left = SW'($urandom); s_right = SW'($urandom);
    base = xfer_edges.size();
    repeat (4) step();
    checks++;
    if (xfer_edges.size() - base != 2) begin failures++; $display("FAIL bp_fill transfers: got %0d expected 2", xfer_edges.size() - base); end
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_full s_ready: got %b expected 0", s_ready); end
    do_enable();
    first = load_edge;
    base = xfer_edges.size();
    repeat (4) run_frame("backpressure");
    n = xfer_edges.size() - base;
    checks++;
    if (n != 4) begin failures++; $display("FAIL bp_rate transfers: got %0d expected 4", n); end
    for (int i = 0; i < n && i < 4; i++) begin
      checks++;
      if (xfer_edges[base+i] != first + 1 + i * FRAME_CYC) begin
        failures++;
        $display("FAIL bp_timing xfer%0d: got edge %0d expected %0d", i, xfer_edges[base+i], first + 1 + i * FRAME_CYC);
      end
    end
    prod_mode = 0; s_valid = 1'b0;
    do_disable();
  endtask

  task automatic test_random();
    prod_mode = 2;
    do_enable();
    repeat (3) run_frame("random");
    prod_mode = 0; s_valid = 1'b0;
    do_disable();
    if (q.size() > 0) begin
      do_enable();
      for (int i = 0; i < 4 && q.size() > 0; i++) run_frame("drain");
      do_disable();
    end
  endtask

  task automatic test_load_collision();
    do_enable();
    sched_l = SW'($urandom); sched_r = SW'($urandom);
    sched_edge = load_edge + FRAME_CYC;
    repeat (3) run_frame("collision");
    checks++;
    if (xfer_edges.size() == 0 || xfer_edges[$] != sched_edge) begin
      failures++; $display("FAIL collision push_edge: expected transfer at edge %0d", sched_edge);
    end
    sched_edge = -1;
    do_disable();
  endtask

  task automatic test_disable_mid();
    tb_pair_t e;
    bit       eu;
    int       bad;
    int       budget;
    s_valid = 1'b1; s_left = SW'($urandom); s_right = SW'($urandom); step();
    s_valid = 1'b1; s_left = SW'($urandom); s_right = SW'($urandom); step();
    do_enable();
    budget = 0;
    while (cyc < load_edge + 160 && budget < 400) begin step(); budget++; end
    model_load(load_edge, e, eu);
    checks++;
    if (i2s_lrck !== 1'b1) begin failures++; $display("FAIL mid_frame lrck: got %b expected 1", i2s_lrck); end
    enable = 1'b0;
    s_valid = 1'b1; s_left = SW'($urandom); s_right = SW'($urandom);
    step();
    checks++; if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL disable bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrck !== 1'b0) begin failures++; $display("FAIL disable lrck: got %b expected 0", i2s_lrck); end
    checks++; if (i2s_dat !== 1'b0) begin failures++; $display("FAIL disable dat: got %b expected 0", i2s_dat); end
    bad = 0;
    repeat (12) begin
      step();
      if (i2s_bclk || i2s_lrck || i2s_dat) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL disable idle_activity: got %0d active cycles expected 0", bad); end
    do_enable();
    run_frame("reenable_next");
    run_frame("reenable_pushed_while_off");
    do_disable();
  endtask

  task automatic test_async_reset();
    int budget;
    prod_mode = 1; s_valid = 1'b1; s_left = SW'($urandom); s_right = SW'($urandom);
    repeat (3) step();
    prod_mode = 0; s_valid = 1'b0;
    do_enable();
    budget = 0;
    while (!(i2s_bclk && i2s_lrck) && budget < 300) begin step(); budget++; end
    checks++;
    if (!(i2s_bclk && i2s_lrck)) begin failures++; $display("FAIL areset setup: bclk/lrck never both high"); end
    #2;
    reset_n = 1'b0;
    enable = 1'b0;
    #1;
    checks++; if (i2s_bclk !== 1'b0) begin failures++; $display("FAIL areset bclk: got %b expected 0", i2s_bclk); end
    checks++; if (i2s_lrck !== 1'b0) begin failures++; $display("FAIL areset lrck: got %b expected 0", i2s_lrck); end
    checks++; if (i2s_dat !== 1'b0) begin failures++; $display("FAIL areset dat: got %b expected 0", i2s_dat); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL areset underrun: got %b expected 0", underrun); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL areset s_ready: got %b expected 1", s_ready); end
    q.delete();
    last.l = '0; last.r = '0; last.edge_n = 0;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    do_enable();
    run_frame("post_reset_empty");
    do_disable();
  endtask

  initial begin
    #1 reset_n = 1'b0;
    last.l = '0; last.r = '0; last.edge_n = 0;
    test_reset();
    test_basic();
    test_underrun();
    test_backpressure();
    test_random();
    test_load_collision();
    test_disable_mid();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
